// File: rtl/timer_pwm_multi.sv
// rtl/timer_pwm_multi.sv - multi-channel timer/PWM core with prescaler, shadowed TOP/CMP and one-shot
// Edge/centre-aligned counter driving N_CH compare outputs, register bus with registered ack.
module timer_pwm_multi #(
  parameter int CNT_W = 16,
  parameter int N_CH  = 4,
  parameter int PRS_W = 8
) (
  input  logic             i_sysclk,
  input  logic             i_sysrst_n,
  input  logic             i_bus_select,
  input  logic             i_bus_wr,
  input  logic [3:0]       i_reg_addr,
  input  logic [15:0]      i_bus_data,
  output logic [15:0]      o_bus_data,
  output logic             o_bus_ack,
  output logic             o_int_flg,
  output logic [N_CH-1:0]  o_pwm,
  output logic [CNT_W-1:0] o_cnt
);
  localparam int SW = N_CH + 1;
  localparam logic [3:0] A_CTRL = 4'd0;
  localparam logic [3:0] A_PRS  = 4'd1;
  localparam logic [3:0] A_TOP  = 4'd2;
  localparam logic [3:0] A_CNT  = 4'd3;
  localparam logic [3:0] A_STAT = 4'd4;
  localparam logic [3:0] A_IER  = 4'd5;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PRS_W-1:0] PRS_ONE = PRS_W'(1);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  logic             en_q, en_d, mode_q, mode_d, oneshot_q, oneshot_d;
  logic [N_CH-1:0]  oe_q, oe_d, pol_q, pol_d, pwm_q, pwm_d;
  logic [PRS_W-1:0] prs_q, prs_d, p_q, p_d;
  logic [CNT_W-1:0] top_sh_q, top_sh_d, top_act_q, top_act_d, cnt_q, cnt_d;
  logic [CNT_W-1:0] cmp_sh_q  [N_CH];
  logic [CNT_W-1:0] cmp_sh_d  [N_CH];
  logic [CNT_W-1:0] cmp_act_q [N_CH];
  logic [CNT_W-1:0] cmp_act_d [N_CH];
  dir_e             dir_q, dir_d;
  logic [SW-1:0]    stat_q, stat_d, ier_q, ier_d;
  logic             ack_q, ack_d;
  logic [15:0]      rdata_q, rdata_d;

  logic             wr_en, rd_en;
  logic             wr_ctrl, wr_prs, wr_top, wr_cnt, wr_stat, wr_ier;
  logic [N_CH-1:0]  wr_cmp, cmp_evt, raw;
  logic             tick, tick_eff, period_evt;
  logic [CNT_W-1:0] wdata_cnt;
  logic             unused_bus;

  assign wdata_cnt  = i_bus_data[CNT_W-1:0];
  assign unused_bus = ^i_bus_data;

  always_comb begin
    wr_en   = i_bus_select & i_bus_wr;
    rd_en   = i_bus_select & ~i_bus_wr;
    wr_ctrl = wr_en && (i_reg_addr == A_CTRL);
    wr_prs  = wr_en && (i_reg_addr == A_PRS);
    wr_top  = wr_en && (i_reg_addr == A_TOP);
    wr_cnt  = wr_en && (i_reg_addr == A_CNT);
    wr_stat = wr_en && (i_reg_addr == A_STAT);
    wr_ier  = wr_en && (i_reg_addr == A_IER);
    for (int ch = 0; ch < N_CH; ch++) begin
      wr_cmp[ch] = wr_en && (i_reg_addr == 4'(8 + ch));
    end
  end

  always_comb begin
    en_d       = en_q;
    mode_d     = mode_q;
    oneshot_d  = oneshot_q;
    oe_d       = oe_q;
    pol_d      = pol_q;
    prs_d      = wr_prs ? i_bus_data[PRS_W-1:0] : prs_q;
    ier_d      = wr_ier ? i_bus_data[SW-1:0] : ier_q;
    p_d        = p_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    period_evt = 1'b0;
    cmp_evt    = '0;
    raw        = '0;
    pwm_d      = pwm_q;

    // A CNT write takes priority over a coincident tick, so the tick is dropped.
    tick     = en_q && (p_q == prs_q);
    tick_eff = tick && !wr_cnt;
    if (!en_q || wr_cnt || tick) p_d = '0;
    else                         p_d = p_q + PRS_ONE;

    if (tick_eff) begin
      if (!mode_q) begin
        if (cnt_q == top_act_q) begin
          cnt_d      = '0;
          period_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else if (dir_q == DIR_UP) begin
        if (cnt_q == top_act_q) begin
          dir_d = DIR_DOWN;
          cnt_d = (top_act_q == '0) ? '0 : top_act_q - CNT_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else begin
        if (cnt_q == '0) begin
          dir_d      = DIR_UP;
          cnt_d      = CNT_ONE;
          period_evt = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
    end

    if (period_evt && oneshot_q) begin
      en_d  = 1'b0;
      cnt_d = '0;
    end
    if (wr_cnt) begin
      cnt_d = wdata_cnt;
      dir_d = DIR_UP;
    end
    if (wr_ctrl) begin
      en_d      = i_bus_data[0];
      mode_d    = i_bus_data[1];
      oneshot_d = i_bus_data[2];
      oe_d      = i_bus_data[4 +: N_CH];
      pol_d     = i_bus_data[8 +: N_CH];
    end

    // Shadows reach the active copies at the period boundary, or directly while stopped.
    top_sh_d = wr_top ? wdata_cnt : top_sh_q;
    if (wr_top && !en_q)  top_act_d = wdata_cnt;
    else if (period_evt)  top_act_d = top_sh_q;
    else                  top_act_d = top_act_q;

    for (int ch = 0; ch < N_CH; ch++) begin
      cmp_sh_d[ch] = wr_cmp[ch] ? wdata_cnt : cmp_sh_q[ch];
      if (wr_cmp[ch] && !en_q) cmp_act_d[ch] = wdata_cnt;
      else if (period_evt)     cmp_act_d[ch] = cmp_sh_q[ch];
      else                     cmp_act_d[ch] = cmp_act_q[ch];
      cmp_evt[ch] = tick_eff && (cnt_q == cmp_act_q[ch]);
      raw[ch]     = cnt_q < cmp_act_q[ch];
      pwm_d[ch]   = en_q ? ((oe_q[ch] & raw[ch]) ^ pol_q[ch]) : pol_q[ch];
    end

    // Hardware sets are OR-ed after the W1C clear so a coincident event survives.
    stat_d = wr_stat ? (stat_q & ~i_bus_data[SW-1:0]) : stat_q;
    stat_d = stat_d | {cmp_evt, period_evt};

    ack_d   = i_bus_select;
    rdata_d = '0;
    if (rd_en) begin
      case (i_reg_addr)
        A_CTRL: begin
          rdata_d[0]         = en_q;
          rdata_d[1]         = mode_q;
          rdata_d[2]         = oneshot_q;
          rdata_d[4 +: N_CH] = oe_q;
          rdata_d[8 +: N_CH] = pol_q;
        end
        A_PRS:   rdata_d[PRS_W-1:0] = prs_q;
        A_TOP:   rdata_d[CNT_W-1:0] = top_sh_q;
        A_CNT:   rdata_d[CNT_W-1:0] = cnt_q;
        A_STAT:  rdata_d[SW-1:0]    = stat_q;
        A_IER:   rdata_d[SW-1:0]    = ier_q;
        default: begin
          for (int ch = 0; ch < N_CH; ch++) begin
            if (i_reg_addr == 4'(8 + ch)) rdata_d[CNT_W-1:0] = cmp_sh_q[ch];
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      en_q      <= 1'b0;
      mode_q    <= 1'b0;
      oneshot_q <= 1'b0;
      oe_q      <= '0;
      pol_q     <= '0;
      pwm_q     <= '0;
      prs_q     <= '0;
      p_q       <= '0;
      top_sh_q  <= '1;
      top_act_q <= '1;
      cnt_q     <= '0;
      dir_q     <= DIR_UP;
      stat_q    <= '0;
      ier_q     <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      for (int ch = 0; ch < N_CH; ch++) begin
        cmp_sh_q[ch]  <= '0;
        cmp_act_q[ch] <= '0;
      end
    end else begin
      en_q      <= en_d;
      mode_q    <= mode_d;
      oneshot_q <= oneshot_d;
      oe_q      <= oe_d;
      pol_q     <= pol_d;
      pwm_q     <= pwm_d;
      prs_q     <= prs_d;
      p_q       <= p_d;
      top_sh_q  <= top_sh_d;
      top_act_q <= top_act_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      stat_q    <= stat_d;
      ier_q     <= ier_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      for (int ch = 0; ch < N_CH; ch++) begin
        cmp_sh_q[ch]  <= cmp_sh_d[ch];
        cmp_act_q[ch] <= cmp_act_d[ch];
      end
    end
  end

  assign o_bus_ack  = ack_q;
  assign o_bus_data = rdata_q;
  assign o_int_flg  = |(stat_q & ier_q);
  assign o_pwm      = pwm_q;
  assign o_cnt      = cnt_q;

endmodule

// File: tb/tb_timer_pwm_multi.sv
// tb/tb_timer_pwm_multi.sv - self-checking bench for timer_pwm_multi
// Bus reads go through an expected-value queue popped on ack; counter/PWM checked per clock.
module tb_timer_pwm_multi;
  logic        clk, rst_n, sel, bwr;
  logic [3:0]  addr;
  logic [15:0] wdata, rdata;
  logic        ack, int_flg;
  logic [3:0]  pwm;
  logic [15:0] cnt;

  typedef struct {
    logic        is_rd;
    logic [3:0]  addr;
    logic [15:0] exp;
  } sb_t;
  sb_t sb_q[$];

  int   n_checks = 0;
  int   n_errors = 0;
  logic sel_seen = 1'b0;

  timer_pwm_multi #(.CNT_W(16), .N_CH(4), .PRS_W(8)) dut (
    .i_sysclk     (clk),
    .i_sysrst_n   (rst_n),
    .i_bus_select (sel),
    .i_bus_wr     (bwr),
    .i_reg_addr   (addr),
    .i_bus_data   (wdata),
    .o_bus_data   (rdata),
    .o_bus_ack    (ack),
    .o_int_flg    (int_flg),
    .o_pwm        (pwm),
    .o_cnt        (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; the access is sampled on the following posedge.
  task automatic bus_xfer(input logic wr, input logic [3:0] a, input logic [15:0] d);
    sb_t e;
    sel = 1'b1; bwr = wr; addr = a; wdata = wr ? d : 16'h0;
    e.is_rd = !wr; e.addr = a; e.exp = wr ? 16'h0 : d;
    sb_q.push_back(e);
    @(negedge clk);
    sel = 1'b0; bwr = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    bus_xfer(1'b1, a, d);
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] exp);
    bus_xfer(1'b0, a, exp);
  endtask

  function automatic int tri_val(input int s);
    int m;
    m = s % 8;
    return (m <= 4) ? m : 8 - m;
  endfunction

  function automatic int act0(input int t);
    if (t < 10) return 3;
    if (t < 40) return 8;
    if (t < 70) return 0;
    return 12;
  endfunction

  always @(posedge clk) sel_seen <= sel;

  always @(negedge clk) begin
    if (rst_n) begin
      check("ack_latency", ack, sel_seen);
      if (ack) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_ack", 1, 0);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          if (e.is_rd) check($sformatf("rd_addr%0d", e.addr), rdata, e.exp);
        end
      end else begin
        check("idle_data", rdata, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sel = 1'b0; bwr = 1'b0; addr = 4'h0; wdata = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_pwm", pwm, 0);
    check("rst_cnt", cnt, 0);
    check("rst_int", int_flg, 0);
    check("rst_ack", ack, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset values and unmapped addresses
    rd(4'd2, 16'hFFFF);
    rd(4'd7, 16'h0000);
    wr(4'd7, 16'h1234);
    rd(4'd7, 16'h0000);
    rd(4'd15, 16'h0000);
    rd(4'd0, 16'h0000);
    rd(4'd3, 16'h0000);

    // Edge PWM: TOP=9, CMP0=3
    wr(4'd1, 16'd0);
    wr(4'd2, 16'd9);
    wr(4'd8, 16'd3);
    wr(4'd5, 16'h0001);
    wr(4'd0, 16'h0011);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      check("edge_cnt", cnt, k % 10);
      check("edge_pwm", pwm, {3'b000, (((k - 1) % 10) < 3)});
      check("edge_int", int_flg, k >= 10);
    end
    rd(4'd4, 16'h001F);
    wr(4'd0, 16'h0000);
    rd(4'd3, 16'd2);
    repeat (3) @(negedge clk);
    rd(4'd3, 16'd2);
    check("idle_pwm", pwm, 0);

    // Centre mode: TOP=4, CMP1=2, PRS=1
    wr(4'd4, 16'h001F);
    wr(4'd3, 16'd0);
    wr(4'd2, 16'd4);
    wr(4'd9, 16'd2);
    wr(4'd1, 16'd1);
    wr(4'd0, 16'h0023);
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      check("ctr_cnt", cnt, tri_val(k / 2));
      check("ctr_pwm", pwm, {2'b00, (tri_val((k - 1) / 2) < 2), 1'b0});
      check("ctr_int", int_flg, k >= 18);
    end
    wr(4'd0, 16'h0000);
    wr(4'd3, 16'd0);

    // Shadowed CMP updates, CMP boundaries and W1C race at the wrap
    wr(4'd4, 16'h001F);
    wr(4'd1, 16'd0);
    wr(4'd2, 16'd9);
    wr(4'd8, 16'd3);
    wr(4'd0, 16'h0011);
    for (int k = 1; k <= 108; k++) begin
      case (k)
        5:       wr(4'd8, 16'd8);
        32:      wr(4'd8, 16'd0);
        62:      wr(4'd8, 16'd12);
        92:      wr(4'd4, 16'h001F);
        100:     wr(4'd4, 16'h0001);
        104:     wr(4'd4, 16'h0001);
        default: @(negedge clk);
      endcase
      check("shd_cnt", cnt, k % 10);
      check("shd_pwm", pwm, {3'b000, (((k - 1) % 10) < act0(k - 1))});
      check("shd_int", int_flg, ((k >= 10) && (k < 92)) || ((k >= 100) && (k < 104)));
    end
    wr(4'd0, 16'h0000);

    // One-shot with TOP=5; CMP0=12 exceeds TOP so raw is always 1
    wr(4'd3, 16'd0);
    wr(4'd2, 16'd5);
    wr(4'd4, 16'h001F);
    wr(4'd0, 16'h0015);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check("os_cnt", cnt, (k < 6) ? k : 0);
      check("os_pwm", pwm, {3'b000, ((k >= 1) && (k <= 6))});
      check("os_int", int_flg, k >= 6);
    end
    rd(4'd0, 16'h0014);

    // Asynchronous reset mid-count
    wr(4'd3, 16'd0);
    wr(4'd0, 16'h0011);
    repeat (3) @(negedge clk);
    check("pre_rst_pwm", pwm, 4'b0001);
    check("pre_rst_cnt", cnt, 3);
    check("pre_rst_int", int_flg, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pwm", pwm, 0);
    check("arst_cnt", cnt, 0);
    check("arst_int", int_flg, 0);
    check("arst_ack", ack, 0);
    check("arst_data", rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(4'd2, 16'hFFFF);
    rd(4'd0, 16'h0000);
    repeat (3) @(negedge clk);
    check("post_rst_cnt", cnt, 0);
    check("post_rst_pwm", pwm, 0);
    check("sb_drain", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
